// File: rtl/mda_vram_fetch.sv
// MDA VRAM fetch: 18-clock character sequencer, char/attr display fetch and
// arbitration of the single-port video RAM between display and CPU.
module mda_vram_fetch #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned CHAR_SLOT = 0,
  parameter int unsigned ATTR_SLOT = 2,
  parameter int unsigned ROM_SLOT  = 3,
  parameter int unsigned PIPE_SLOT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       crtc_addr,
  output logic              crtc_tick,
  output logic [4:0]        clk_seq,
  output logic [7:0]        vram_data,
  output logic              vram_read_char,
  output logic              vram_read_att,
  output logic              charrom_read,
  output logic              disp_pipeline,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack
);

  localparam int unsigned SeqLen = 18;

  localparam logic [4:0] CharSlot = 5'(CHAR_SLOT);
  localparam logic [4:0] AttrSlot = 5'(ATTR_SLOT);
  localparam logic [4:0] RomSlot  = 5'(ROM_SLOT);
  localparam logic [4:0] PipeSlot = 5'(PIPE_SLOT);
  localparam logic [4:0] TickSlot = 5'((CHAR_SLOT + SeqLen - 2) % SeqLen);
  localparam logic [4:0] CharCap  = 5'((CHAR_SLOT + 1) % SeqLen);
  localparam logic [4:0] AttrCap  = 5'((ATTR_SLOT + 1) % SeqLen);
  localparam logic [4:0] CharRdy  = 5'((CHAR_SLOT + 2) % SeqLen);
  localparam logic [4:0] AttrRdy  = 5'((ATTR_SLOT + 2) % SeqLen);

  typedef enum logic [1:0] {CIdle, CAddr, CData, CAck} cpu_state_e;

  cpu_state_e cpu_state;
  logic [4:0] seq_next;
  logic       disp_next;
  logic       cpu_accept;

  // Strobes and addresses are registered, so they are decoded from the value
  // clk_seq takes in the next cycle.
  always_comb begin
    seq_next   = (clk_seq == 5'(SeqLen - 1)) ? 5'd0 : clk_seq + 5'd1;
    disp_next  = (seq_next == CharSlot) || (seq_next == AttrSlot);
    cpu_accept = (cpu_state == CIdle) && cpu_req && !disp_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_seq        <= 5'd0;
      crtc_tick      <= 1'b0;
      vram_data      <= 8'h00;
      vram_read_char <= 1'b0;
      vram_read_att  <= 1'b0;
      charrom_read   <= 1'b0;
      disp_pipeline  <= 1'b0;
      ram_addr       <= '0;
      ram_we         <= 1'b0;
      ram_wdata      <= 8'h00;
      cpu_rdata      <= 8'h00;
      cpu_ack        <= 1'b0;
      cpu_state      <= CIdle;
    end else begin
      clk_seq        <= seq_next;
      crtc_tick      <= (seq_next == TickSlot);
      vram_read_char <= (seq_next == CharRdy);
      vram_read_att  <= (seq_next == AttrRdy);
      charrom_read   <= (seq_next == RomSlot);
      disp_pipeline  <= (seq_next == PipeSlot);

      if ((clk_seq == CharCap) || (clk_seq == AttrCap)) begin
        vram_data <= ram_rdata;
      end

      // Display slots own the RAM port; a CPU access only starts when the
      // following cycle is free, so its single write cycle never collides.
      ram_we <= 1'b0;
      if (seq_next == CharSlot) begin
        ram_addr <= ADDR_W'({crtc_addr, 1'b0});
      end else if (seq_next == AttrSlot) begin
        ram_addr <= ADDR_W'({crtc_addr, 1'b1});
      end else if (cpu_accept) begin
        ram_addr  <= cpu_addr;
        ram_we    <= cpu_we;
        ram_wdata <= cpu_wdata;
      end

      cpu_ack <= 1'b0;
      unique case (cpu_state)
        CIdle: begin
          if (cpu_accept) begin
            cpu_state <= CAddr;
          end
        end
        CAddr: cpu_state <= CData;
        CData: begin
          cpu_rdata <= ram_rdata;
          cpu_ack   <= 1'b1;
          cpu_state <= CAck;
        end
        CAck:    cpu_state <= CIdle;
        default: cpu_state <= CIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mda_vram_fetch.sv
// Randomised bench for mda_vram_fetch: the bench models the VRAM and predicts
// every output cycle by cycle from the character timing rules.
module tb_mda_vram_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] crtc_addr = 11'h123;
  logic        crtc_tick;
  logic [4:0]  clk_seq;
  logic [7:0]  vram_data;
  logic        vram_read_char, vram_read_att, charrom_read, disp_pipeline;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_addr = 12'h000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  always #5 clk = ~clk;

  mda_vram_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .crtc_addr      (crtc_addr),
    .crtc_tick      (crtc_tick),
    .clk_seq        (clk_seq),
    .vram_data      (vram_data),
    .vram_read_char (vram_read_char),
    .vram_read_att  (vram_read_att),
    .charrom_read   (charrom_read),
    .disp_pipeline  (disp_pipeline),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_ack        (cpu_ack)
  );

  // Single-port VRAM, read data one cycle after the address.
  logic [7:0] ram [4096];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // Reference model state.
  logic [7:0]  ref_mem [4096];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic        op_active = 1'b0;
  logic        op_we = 1'b0;
  logic [11:0] op_addr = 12'h000;
  logic [7:0]  op_wdata = 8'h00;
  int          op_acc = 0;
  int          op_ack_cyc = 0;
  int          idle_from = 0;
  logic [7:0]  exp_char = 8'h00;
  logic [7:0]  exp_attr = 8'h00;
  int          ack_seq = 99;
  int          we_seq = 99;
  logic [7:0]  ack_rdata = 8'h00;
  logic        wr_toggle = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Called at the falling edge of cycle cyc (cycles counted from reset release).
  task automatic model_check();
    int          s;
    logic [11:0] a;
    logic        we_exp, ack_exp;
    s = cyc % 18;
    check("clk_seq", 32'(clk_seq), s);
    check("crtc_tick", 32'(crtc_tick), 32'(s == 16));
    check("vram_read_char", 32'(vram_read_char), 32'(s == 2));
    check("vram_read_att", 32'(vram_read_att), 32'(s == 4));
    check("charrom_read", 32'(charrom_read), 32'(s == 3));
    check("disp_pipeline", 32'(disp_pipeline), 32'(s == 3));
    if (cyc >= 20)
      check("vram_data", 32'(vram_data), 32'((s == 2 || s == 3) ? exp_char : exp_attr));
    we_exp = op_active && op_we && (cyc == op_acc + 1);
    check("ram_we", 32'(ram_we), 32'(we_exp));
    if (s == 0 || s == 2) begin
      a = {crtc_addr, (s == 2)};
      check("disp_addr", 32'(ram_addr), 32'(a));
      if (s == 0) exp_char = ref_mem[a];
      else        exp_attr = ref_mem[a];
    end
    if (op_active && cyc == op_acc + 1) begin
      check("cpu_ram_addr", 32'(ram_addr), 32'(op_addr));
      if (op_we) begin
        check("ram_wdata", 32'(ram_wdata), 32'(op_wdata));
        ref_mem[op_addr] = op_wdata;
      end
    end
    ack_exp = op_active && (cyc == op_ack_cyc);
    check("cpu_ack", 32'(cpu_ack), 32'(ack_exp));
    if (cpu_ack) begin
      ack_seq   = int'(clk_seq);
      ack_rdata = cpu_rdata;
    end
    if (ram_we) we_seq = int'(clk_seq);
    if (ack_exp) begin
      if (!op_we) check("cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[op_addr]));
      op_active = 1'b0;
      cpu_req   = 1'b0;
      idle_from = cyc + 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    model_check();
  endtask

  // Accept happens in the first idle cycle whose successor is not a display slot.
  task automatic issue(input logic we, input logic [11:0] addr, input logic [7:0] data);
    int r;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = data;
    op_active = 1'b1;
    op_we     = we;
    op_addr   = addr;
    op_wdata  = data;
    r = (cyc > idle_from) ? cyc : idle_from;
    while ((r + 1) % 18 == 0 || (r + 1) % 18 == 2) r++;
    op_acc     = r;
    op_ack_cyc = r + 3;
    ack_seq    = 99;
    we_seq     = 99;
  endtask

  task automatic finish_op();
    while (op_active) step();
  endtask

  // Entered at a falling edge; checks the cleared state after one reset edge.
  task automatic do_reset();
    reset     = 1'b1;
    cpu_req   = 1'b0;
    op_active = 1'b0;
    @(negedge clk);
    check("rst_clk_seq", 32'(clk_seq), 0);
    check("rst_crtc_tick", 32'(crtc_tick), 0);
    check("rst_vram_data", 32'(vram_data), 0);
    check("rst_strobes", 32'({vram_read_char, vram_read_att, charrom_read, disp_pipeline}), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_wdata", 32'(ram_wdata), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    reset     = 1'b0;
    cyc       = 0;
    idle_from = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      ram[i] <= v;
      ref_mem[i] = v;
    end
    ram[12'h246] <= 8'h41;
    ram[12'h247] <= 8'h07;
    ref_mem[12'h246] = 8'h41;
    ref_mem[12'h247] = 8'h07;

    repeat (2) @(negedge clk);
    do_reset();

    // Free-running sequencer and a fixed cell address.
    while (cyc < 20) step();
    check("t2_char", 32'(vram_data), 32'h41);
    check("t2_char_strobe", 32'(vram_read_char), 1);
    while (cyc < 22) step();
    check("t2_attr", 32'(vram_data), 32'h07);
    check("t2_attr_strobe", 32'(vram_read_att), 1);
    while (cyc < 40) step();

    // Write requested in cycle 5, then read it back.
    while (cyc % 18 != 5) step();
    issue(1'b1, 12'h010, 8'hAA);
    finish_op();
    check("t3_we_seq", we_seq, 6);
    check("t3_ack_seq", ack_seq, 8);
    step();
    issue(1'b0, 12'h010, 8'h00);
    finish_op();
    check("t3_readback", 32'(ack_rdata), 32'hAA);

    // Request in cycle 17 must wait past the char slot.
    step();
    while (cyc % 18 != 17) step();
    issue(1'b0, 12'h010, 8'h00);
    finish_op();
    check("t4_ack_seq", ack_seq, 3);
    check("t4_rdata", 32'(ack_rdata), 32'hAA);

    // Back-to-back random CPU traffic over addresses the display also fetches.
    for (int i = 0; i < 300; i++) begin
      step();
      if (cyc % 18 == 16) crtc_addr = 11'($urandom_range(0, 31));
      if (!op_active) begin
        issue(wr_toggle, 12'($urandom_range(0, 63)), 8'($urandom));
        wr_toggle = !wr_toggle;
      end
    end
    finish_op();

    // Reset while a read sits in its data cycle.
    step();
    issue(1'b0, 12'h020, 8'h00);
    while (cyc != op_acc + 2) step();
    do_reset();
    repeat (40) step();
    issue(1'b1, 12'h030, 8'h5C);
    finish_op();
    step();
    issue(1'b0, 12'h030, 8'h00);
    finish_op();
    check("t6_readback", 32'(ack_rdata), 32'h5C);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
